// File: rtl/bp_fe_pkg.sv
// Shared types for the FE BHT update queue: FSM states and the entry struct macro.
// The entry struct width follows the BHT index width of the instantiating module.
package bp_fe_pkg;

    typedef enum logic {
        e_updq_run    = 1'b0,
        e_updq_squash = 1'b1
    } bp_fe_bht_updq_state_e;

endpackage

`define BP_FE_DECLARE_BHT_UPDQ_ENTRY_S(idx_width_mp) \
    typedef struct packed { \
        logic [idx_width_mp-1:0] idx; \
        logic                    taken; \
    } bp_fe_bht_updq_entry_s

// File: rtl/bp_fe_bht_updq_mem.sv
// Reset-free register file holding in-flight predictions: one write port and
// one asynchronous read port.
module bp_fe_bht_updq_mem
    import bp_fe_pkg::*;
#(
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 8,
    localparam int ptr_width_lp   = $clog2(els_p),
    localparam int entry_width_lp = bht_idx_width_p + 1
)
(
    input  logic                      clk_i,
    input  logic                      w_v_i,
    input  logic [ptr_width_lp-1:0]   w_addr_i,
    input  logic [entry_width_lp-1:0] w_data_i,
    input  logic [ptr_width_lp-1:0]   r_addr_i,
    output logic [entry_width_lp-1:0] r_data_o
);

    logic [entry_width_lp-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_bht_update_queue.sv
// In-order queue of BHT predictions that emits one BHT update per backend resolution.
// Optional BP_FE_BHT_UPDQ_BYPASS_EN resolves a record straight through an empty queue.
module bp_fe_bht_update_queue
    import bp_fe_pkg::*;
#(
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 8,
    localparam int ptr_width_lp   = $clog2(els_p),
    localparam int cnt_width_lp   = $clog2(els_p + 1)
)
(
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       pred_v_i,
    input  logic [bht_idx_width_p-1:0] pred_idx_i,
    input  logic                       pred_taken_i,
    output logic                       pred_ready_o,
    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    output logic                       res_ready_o,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic                       mispredict_o,
    output logic [cnt_width_lp-1:0]    count_o
);

    `BP_FE_DECLARE_BHT_UPDQ_ENTRY_S(bht_idx_width_p);

    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

    bp_fe_bht_updq_state_e   state_r, state_n;
    logic [ptr_width_lp-1:0] rptr_r, rptr_n, wptr_r, wptr_n;
    logic [cnt_width_lp-1:0] count_r, count_n;
    bp_fe_bht_updq_entry_s   rd_data, wr_data, head;
    logic                    bypass, enq, deq, deq_mem, correct_n, mispred, squash;

`ifdef BP_FE_BHT_UPDQ_BYPASS_EN
    assign bypass = (count_r == '0) && (state_r == e_updq_run) && !flush_i && pred_v_i && res_v_i;
`else
    assign bypass = 1'b0;
`endif

    // Handshake outputs
    always_comb begin
        pred_ready_o = (state_r == e_updq_run) && (count_r != full_cnt_lp) && !flush_i;
        res_ready_o  = (count_r != '0) || bypass;
    end

    assign wr_data = '{idx: pred_idx_i, taken: pred_taken_i};
    assign head    = bypass ? wr_data : rd_data;

    assign deq       = res_v_i && res_ready_o;
    assign deq_mem   = deq && !bypass;
    assign correct_n = (head.taken == res_taken_i);
    assign mispred   = deq && !correct_n;
    assign squash    = mispred || flush_i;
    // A squash drops the same-cycle record; a bypassed record never touches storage.
    assign enq       = pred_v_i && pred_ready_o && !mispred && !bypass;

    bp_fe_bht_updq_mem #(
        .bht_idx_width_p(bht_idx_width_p),
        .els_p          (els_p)
    ) mem (
        .clk_i   (clk_i),
        .w_v_i   (enq),
        .w_addr_i(wptr_r),
        .w_data_i(wr_data),
        .r_addr_i(rptr_r),
        .r_data_o(rd_data)
    );

    always_comb begin
        state_n = squash ? e_updq_squash : e_updq_run;
    end

    always_comb begin
        rptr_n = rptr_r + ptr_width_lp'(deq_mem);
        if (squash) begin
            wptr_n  = rptr_n;
            count_n = '0;
        end else begin
            wptr_n  = wptr_r + ptr_width_lp'(enq);
            count_n = count_r + cnt_width_lp'(enq) - cnt_width_lp'(deq_mem);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_updq_run;
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            state_r <= state_n;
            rptr_r  <= rptr_n;
            wptr_r  <= wptr_n;
            count_r <= count_n;
        end
    end

    // BHT update port, one cycle behind the dequeue
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_o        <= 1'b0;
            idx_w_o      <= '0;
            correct_o    <= 1'b0;
            mispredict_o <= 1'b0;
        end else begin
            w_v_o        <= deq;
            mispredict_o <= mispred;
            if (deq) begin
                idx_w_o   <= head.idx;
                correct_o <= correct_n;
            end
        end
    end

    assign count_o = count_r;

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Randomized bench for bp_fe_bht_update_queue against a queue-based reference model.
module tb_bp_fe_bht_update_queue;

    localparam int IW = 9;
    localparam int N  = 8;
`ifdef BP_FE_BHT_UPDQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          pred_v_i, pred_taken_i, pred_ready_o;
    logic [IW-1:0] pred_idx_i;
    logic          res_v_i, res_taken_i, res_ready_o, flush_i;
    logic          w_v_o, correct_o, mispredict_o;
    logic [IW-1:0] idx_w_o;
    logic [3:0]    count_o;

    bp_fe_bht_update_queue #(.bht_idx_width_p(IW), .els_p(N)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .pred_v_i    (pred_v_i),
        .pred_idx_i  (pred_idx_i),
        .pred_taken_i(pred_taken_i),
        .pred_ready_o(pred_ready_o),
        .res_v_i     (res_v_i),
        .res_taken_i (res_taken_i),
        .res_ready_o (res_ready_o),
        .flush_i     (flush_i),
        .w_v_o       (w_v_o),
        .idx_w_o     (idx_w_o),
        .correct_o   (correct_o),
        .mispredict_o(mispredict_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IW-1:0] idx;
        bit            taken;
    } ent_t;

    ent_t          q[$];
    bit            m_squash;
    bit            e_wv, e_corr, e_mis;
    logic [IW-1:0] e_idx;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic step(input bit pv, input logic [IW-1:0] pi, input bit pt,
                        input bit rv, input bit rt, input bit fl);
        bit   run, byp, e_pr, e_rr, deq, mis, enq;
        ent_t head;
        pred_v_i = pv; pred_idx_i = pi; pred_taken_i = pt;
        res_v_i = rv; res_taken_i = rt; flush_i = fl;
        #1;
        run  = !m_squash;
        byp  = BYP && (q.size() == 0) && run && !fl && pv && rv;
        e_pr = run && (q.size() != N) && !fl;
        e_rr = (q.size() != 0) || byp;
        chk("pred_ready", pred_ready_o, e_pr);
        chk("res_ready", res_ready_o, e_rr);
        chk("count_pre", count_o, q.size());
        deq = rv && e_rr;
        mis = 1'b0;
        if (deq) begin
            if (byp) begin
                head.idx = pi; head.taken = pt;
            end else begin
                head = q.pop_front();
            end
            mis    = (head.taken != rt);
            e_idx  = head.idx;
            e_corr = !mis;
        end
        enq = pv && e_pr && !mis && !byp;
        if (mis || fl) begin
            q.delete();
        end else if (enq) begin
            head.idx = pi; head.taken = pt;
            q.push_back(head);
        end
        m_squash = mis || fl;
        e_wv  = deq;
        e_mis = mis;
        @(posedge clk_i);
        #1;
        chk("w_v", w_v_o, e_wv);
        chk("mispredict", mispredict_o, e_mis);
        chk("idx_w", idx_w_o, e_idx);
        chk("correct", correct_o, e_corr);
        chk("count_post", count_o, q.size());
        @(negedge clk_i);
    endtask

    initial begin
        bit       pv, rv, rt, fl;
        reset_n_i = 1'b0;
        pred_v_i = 0; pred_idx_i = '0; pred_taken_i = 0;
        res_v_i = 0; res_taken_i = 0; flush_i = 0;
        m_squash = 0; e_wv = 0; e_corr = 0; e_mis = 0; e_idx = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_w_v", w_v_o, 0);
        chk("rst_idx", idx_w_o, 0);
        chk("rst_correct", correct_o, 0);
        chk("rst_mispredict", mispredict_o, 0);
        chk("rst_count", count_o, 0);
        reset_n_i = 1'b1;

        // Single correct prediction
        step(1, 9'h05, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("tp1_w_v", w_v_o, 1);
        chk("tp1_idx", idx_w_o, 9'h05);
        chk("tp1_correct", correct_o, 1);
        chk("tp1_count", count_o, 0);

        // Fill to capacity, then drain in order across the pointer wrap
        for (int i = 0; i < N; i++) step(1, 9'(i), i[0], 0, 0, 0);
        step(1, 9'h1ff, 0, 0, 0, 0);
        chk("full_ready", pred_ready_o, 0);
        chk("full_count", count_o, N);
        for (int i = 0; i < N; i++) begin
            step(0, 0, 0, 1, i[0], 0);
            chk("drain_idx", idx_w_o, 9'(i));
        end

        // Misprediction squashes younger entries
        step(1, 9'h10, 0, 0, 0, 0);
        step(1, 9'h11, 1, 0, 0, 0);
        step(1, 9'h12, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("mis_pulse", mispredict_o, 1);
        chk("mis_correct", correct_o, 0);
        chk("mis_count", count_o, 0);
        chk("squash_ready", pred_ready_o, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("run_ready", pred_ready_o, 1);

        // Flush with same-cycle resolution and record
        step(1, 9'h20, 1, 0, 0, 0);
        step(1, 9'h21, 1, 0, 0, 0);
        step(1, 9'h22, 0, 0, 0, 0);
        step(1, 9'h33, 1, 1, 1, 1);
        chk("flush_w_v", w_v_o, 1);
        chk("flush_idx", idx_w_o, 9'h20);
        chk("flush_count", count_o, 0);
        step(1, 9'h34, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Resolution against an empty queue
        repeat (3) begin
            step(0, 0, 0, 1, 1, 0);
            chk("empty_w_v", w_v_o, 0);
        end
        step(1, 9'h44, 0, 1, 0, 0);
        chk("bypass_w_v", w_v_o, BYP);
        step(0, 0, 0, 1, 0, 0);

        // Asynchronous reset with entries in flight
        for (int i = 0; i < 4; i++) step(1, 9'(9'h50 + i), 1, 0, 0, 0);
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_w_v", w_v_o, 0);
        chk("arst_idx", idx_w_o, 0);
        chk("arst_correct", correct_o, 0);
        chk("arst_mispredict", mispredict_o, 0);
        chk("arst_count", count_o, 0);
        q.delete();
        m_squash = 0; e_wv = 0; e_corr = 0; e_mis = 0; e_idx = '0;
        pred_v_i = 0; res_v_i = 0; flush_i = 0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            pv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 29) == 0);
            if (q.size() != 0 && $urandom_range(0, 9) != 0) rt = q[0].taken;
            else rt = 1'($urandom_range(0, 1));
            step(pv, 9'($urandom), 1'($urandom_range(0, 1)), rv, rt, fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
